// File: rtl/bcd_pkg.sv
// bcd_pkg: packed BCD price type shared by the order-book blocks.
package bcd_pkg;
  localparam int PRICE_DIGITS = 4;
  typedef logic [4*PRICE_DIGITS-1:0] price_t;
endpackage

// File: rtl/ob_pkg.sv
// ob_pkg: order-book command, status and sizing definitions.
package ob_pkg;
  import bcd_pkg::*;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  typedef logic [7:0] uid_t;
  typedef logic [7:0] qty_t;
  typedef enum logic [2:0] {Op_Nop = 3'd0, Op_QryBidAsk = 3'd1, Op_Buy = 3'd2, Op_Sell = 3'd3} opcode_t;
  typedef enum logic [1:0] {S_Ok, S_BadOpcode, S_BadQty, S_BadPrice} status_t;
  typedef struct packed {qty_t quantity; price_t price;} oprand_buy_t;
  typedef struct packed {qty_t quantity; price_t price;} oprand_sell_t;
  typedef union packed {oprand_buy_t buy; oprand_sell_t sell;} oprand_t;
  typedef struct packed {uid_t uid; opcode_t opcode; oprand_t oprand;} cmd_t;
  function automatic logic is_valid_bcd(price_t p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < PRICE_DIGITS; i++) ok &= (p[4*i+:4] <= 4'd9);
    return ok;
  endfunction
endpackage

// File: rtl/ob_cmd_fifo.sv
// ob_cmd_fifo: command storage with wrap-bit pointers for full/empty.
module ob_cmd_fifo
  import ob_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  cmd_t mem [DEPTH];
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/ob_cmd_ingress.sv
// ob_cmd_ingress: validates host commands, queues good ones for ob, returns rejects.
// Optional OB_CMD_INGRESS_STATS_EN adds saturating accept/reject counters.
module ob_cmd_ingress
  import ob_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_vld,
  input  cmd_t    in_cmd,
  output logic    in_ready,
  output logic    cmd_vld_r,
  output cmd_t    cmd_r,
  input  logic    cmd_full_r,
  output logic    rej_vld_r,
  output uid_t    rej_uid_r,
  output status_t rej_status_r,
  input  logic    rej_accept
`ifdef OB_CMD_INGRESS_STATS_EN
  ,
  output logic [31:0] stat_acc_r,
  output logic [31:0] stat_rej_r
`endif
);
  logic full, empty, xfer, push, pop, is_trade, bad;
  status_t status;
  cmd_t head;
  assign in_ready = !full && !rej_vld_r && !rst;
  assign xfer = in_vld && in_ready;
  // buy and sell oprands share one layout, so the buy view validates both
  always_comb begin
    is_trade = in_cmd.opcode inside {Op_Buy, Op_Sell};
    status = !(in_cmd.opcode inside {Op_Nop, Op_QryBidAsk, Op_Buy, Op_Sell}) ? S_BadOpcode :
             (is_trade && in_cmd.oprand.buy.quantity == '0) ? S_BadQty :
             (is_trade && !is_valid_bcd(in_cmd.oprand.buy.price)) ? S_BadPrice : S_Ok;
  end
  assign bad = status != S_Ok;
  assign push = xfer && !bad;
  assign pop = !empty && !cmd_full_r;
  ob_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata(in_cmd), .rdata(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_vld_r <= 1'b0;
      cmd_r <= '0;
    end else begin
      cmd_vld_r <= pop;
      if (pop) cmd_r <= head;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rej_vld_r <= 1'b0;
      rej_uid_r <= '0;
      rej_status_r <= S_Ok;
    end else if (xfer && bad) begin
      rej_vld_r <= 1'b1;
      rej_uid_r <= in_cmd.uid;
      rej_status_r <= status;
    end else if (rej_accept) begin
      rej_vld_r <= 1'b0;
    end
`ifdef OB_CMD_INGRESS_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_acc_r <= '0;
      stat_rej_r <= '0;
    end else begin
      if (push && stat_acc_r != '1) stat_acc_r <= stat_acc_r + 32'd1;
      if (xfer && bad && stat_rej_r != '1) stat_rej_r <= stat_rej_r + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ob_cmd_ingress.sv
// tb_ob_cmd_ingress: directed and random stimulus against a queue-level reference model.
module tb_ob_cmd_ingress;
  import ob_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, in_vld = 0, cmd_full_r = 0, rej_accept = 0;
  logic in_ready, cmd_vld_r, rej_vld_r;
  cmd_t in_cmd = '0, cmd_r;
  uid_t rej_uid_r;
  status_t rej_status_r;
`ifdef OB_CMD_INGRESS_STATS_EN
  logic [31:0] stat_acc_r, stat_rej_r;
`endif
  int checks = 0, errors = 0;
  cmd_t m_q[$];
  logic m_vld, m_rej, m_xfer;
  cmd_t m_cmd;
  uid_t m_uid;
  status_t m_st;
  int unsigned m_acc, m_rejn;

  always #5 clk = ~clk;

  ob_cmd_ingress #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cmd(in_cmd), .in_ready(in_ready),
    .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .rej_vld_r(rej_vld_r), .rej_uid_r(rej_uid_r), .rej_status_r(rej_status_r),
    .rej_accept(rej_accept)
`ifdef OB_CMD_INGRESS_STATS_EN
    , .stat_acc_r(stat_acc_r), .stat_rej_r(stat_rej_r)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] uid, input logic [2:0] op, input logic [7:0] qty, input logic [15:0] price);
    cmd_t c;
    c = '0;
    c.uid = uid;
    c.opcode = opcode_t'(op);
    c.oprand.buy.quantity = qty;
    c.oprand.buy.price = price;
    return c;
  endfunction

  function automatic status_t ref_status(input cmd_t c);
    int op = int'(c.opcode);
    int q = int'(c.oprand.buy.quantity);
    int p = int'(c.oprand.buy.price);
    if (op > 3) return S_BadOpcode;
    if (op < 2) return S_Ok;
    if (q == 0) return S_BadQty;
    for (int i = 0; i < 4; i++) if ((p >> (4 * i)) % 16 > 9) return S_BadPrice;
    return S_Ok;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [15:0] price;
    logic [2:0] op;
    logic [7:0] qty;
    price = '0;
    for (int i = 0; i < 4; i++) price = price * 16 + 16'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) price = 16'($urandom);
    op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    qty = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    return mk(8'($urandom), op, qty, price);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_vld = 0; m_cmd = '0; m_rej = 0; m_uid = '0; m_st = S_Ok;
    m_acc = 0; m_rejn = 0; m_xfer = 0;
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, m_q.size() < DEPTH && !m_rej && !rst);
    chk("cmd_vld_r", cmd_vld_r, m_vld);
    chk("cmd_r", cmd_r, m_cmd);
    chk("rej_vld_r", rej_vld_r, m_rej);
    chk("rej_uid_r", rej_uid_r, m_uid);
    chk("rej_status_r", rej_status_r, m_st);
`ifdef OB_CMD_INGRESS_STATS_EN
    chk("stat_acc_r", stat_acc_r, m_acc);
    chk("stat_rej_r", stat_rej_r, m_rejn);
`endif
  endtask

  // drive at negedge, advance the model by one edge, check at the next negedge
  task automatic cycle(input logic v, input cmd_t c, input logic f, input logic a);
    status_t s;
    in_vld = v; in_cmd = c; cmd_full_r = f; rej_accept = a;
    s = ref_status(c);
    m_xfer = v && m_q.size() < DEPTH && !m_rej;
    if (m_q.size() > 0 && !f) begin
      m_vld = 1; m_cmd = m_q.pop_front();
    end else m_vld = 0;
    if (m_xfer) begin
      if (s == S_Ok) begin
        m_q.push_back(c); m_acc++;
      end else begin
        m_rej = 1; m_uid = c.uid; m_st = s; m_rejn++;
      end
    end else if (a) m_rej = 0;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    logic v, held;
    int tries;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 0;
    cycle(1, mk(8'h11, Op_Buy, 8'd10, 16'h0123), 0, 0);
    repeat (3) cycle(0, '0, 0, 0);
    cycle(1, mk(8'h22, Op_Sell, 8'd0, 16'h0100), 0, 0);
    c = mk(8'h23, Op_Buy, 8'd3, 16'h0099);
    cycle(1, c, 0, 0);
    cycle(1, c, 0, 1);
    cycle(1, c, 0, 0);
    chk("held_accept", m_xfer, 1'b1);
    repeat (2) cycle(0, '0, 0, 0);
    cycle(1, mk(8'h33, Op_Buy, 8'd5, 16'h01A5), 0, 0);
    cycle(0, '0, 0, 1);
    cycle(1, mk(8'h44, 3'd6, 8'd0, 16'hFFFF), 0, 0);
    chk("opc_prio", rej_status_r, S_BadOpcode);
    cycle(0, '0, 0, 1);
    for (int u = 1; u <= 4; u++) cycle(1, mk(8'(u), Op_Buy, 8'(u), 16'h0100 + 16'(u)), 1, 0);
    chk("fill_ready", in_ready, 1'b0);
    c = mk(8'd5, Op_Sell, 8'd5, 16'h0105);
    repeat (3) cycle(1, c, 1, 0);
    tries = 0;
    do begin
      cycle(1, c, 0, 0);
      tries++;
    end while (!m_xfer && tries < 10);
    chk("uid5_accept", m_xfer, 1'b1);
    repeat (8) cycle(0, '0, 0, 0);
    for (int u = 1; u <= 3; u++) cycle(1, mk(8'(u + 8'h40), Op_Buy, 8'd1, 16'h0001), 1, 0);
    cycle(1, mk(8'h50, Op_Sell, 8'd0, 16'h0001), 1, 0);
    in_vld = 0; rej_accept = 0; cmd_full_r = 0;
    #2 rst = 1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 0;
    repeat (4) cycle(0, '0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 5) cycle(1, mk(8'(i), Op_Buy, 8'd0, 16'h0010), 0, 0);
      else cycle(1, mk(8'(i), Op_Sell, 8'd7, 16'h0010), 0, 0);
      if (m_rej) cycle(0, '0, 0, 1);
    end
    repeat (4) cycle(0, '0, 0, 0);
`ifdef OB_CMD_INGRESS_STATS_EN
    chk("stat_acc6", stat_acc_r, 32'd6);
    chk("stat_rej2", stat_rej_r, 32'd2);
`endif
    v = 0; c = '0; held = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!held) begin
        v = $urandom_range(0, 99) < 70;
        c = rand_cmd();
      end
      cycle(v, c, $urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
      held = v && !m_xfer;
    end
    repeat (DEPTH + 2) cycle(0, '0, 0, 1);
    chk("drained", m_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ob_cmd_ingress.md
Name: ob_cmd_ingress

Overview:
- Command ingress stage directly upstream of the order book (ob).
- Accepts host commands on a valid/ready interface, validates them, and buffers valid ones in a FIFO.
- Issues buffered commands to ob on its cmd_vld_r/cmd_r port, honouring ob's registered cmd_full_r back-pressure.
- Malformed commands never reach ob. Each one returns a reject response carrying its UID.

Parameters:
- FIFO_DEPTH, 4: number of command entries; power of two, minimum 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_vld  input  1  host command valid
- in_cmd  input  $bits(ob_pkg::cmd_t)  host command (uid, opcode, oprand)
- in_ready  output  1  ingress can accept in_cmd this cycle
- cmd_vld_r  output  1  command valid to ob (registered)
- cmd_r  output  $bits(ob_pkg::cmd_t)  command to ob (registered)
- cmd_full_r  input  1  ob command queue full (registered in ob)
- rej_vld_r  output  1  reject response pending
- rej_uid_r  output  $bits(ob_pkg::uid_t)  UID of rejected command
- rej_status_r  output  $bits(ob_pkg::status_t)  reject reason
- rej_accept  input  1  consumer takes the reject response

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: FIFO empty, pointers 0, cmd_vld_r=0, cmd_r='0, rej_vld_r=0, rej_uid_r='0, rej_status_r='0. in_ready is combinational and reads 0 during reset.
- Reset mid-operation: all queued and pending commands are discarded. No partial issue to ob.
- in_ready = !fifo_full && !rej_vld_r && !rst.
- Host transfer: occurs at a rising edge with in_vld && in_ready. A stalled host must hold in_cmd stable.
- Validation (combinational on in_cmd): a command is invalid when any of the following holds:
  - opcode is not Op_Nop, Op_QryBidAsk, Op_Buy or Op_Sell: status S_BadOpcode;
  - Op_Buy or Op_Sell with quantity == 0: status S_BadQty;
  - Op_Buy or Op_Sell with any 4-bit price digit > 9 (bcd_pkg::price_t must be valid BCD): status S_BadPrice.
  - Priority when several checks fail: opcode, then quantity, then price.
- Valid transfer: the command is written to the FIFO at wr_ptr, and wr_ptr increments modulo FIFO_DEPTH.
- Invalid transfer: the command is not enqueued. rej_vld_r=1, rej_uid_r=uid, rej_status_r=reason are set at the same edge.
- Reject hold: rej_vld_r holds until an edge with rej_accept=1, then clears. in_ready is low while rej_vld_r=1, so only one reject is ever outstanding.
- Issue to ob, evaluated each edge:
  - if the FIFO is non-empty and cmd_full_r==0, set cmd_vld_r=1, set cmd_r to the head entry, and increment rd_ptr;
  - otherwise cmd_vld_r=0 and cmd_r holds its value.
  - cmd_vld_r is a one-cycle pulse per command. ob accepts any cycle it sees cmd_vld_r, because cmd_full_r leaves one slot of skid.
- Latency: a valid command accepted at edge N appears on cmd_vld_r after edge N+1 at the earliest. There is no bypass path.
- Ordering: commands issue in strict acceptance order. Rejects do not reorder valid commands.
- Occupancy: the FIFO uses pointers with an extra wrap bit. full = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal). empty = (pointers equal).
- Simultaneous push and pop:
  - when full, in_ready is already low, so no write occurs that cycle even if a pop happens;
  - when not full and not empty, push and pop both occur and occupancy is unchanged;
  - when empty, the push occurs and no pop occurs that cycle.
- cmd_full_r asserted indefinitely: the FIFO fills, in_ready drops, and no command is lost or duplicated.

Optional Feature:
- Macro: OB_CMD_INGRESS_STATS_EN.
- With the macro: add outputs stat_acc_r and stat_rej_r (32 bits each), reset to 0.
  - stat_acc_r increments on each valid transfer; stat_rej_r increments on each reject.
  - Both saturate at 2^32-1 and do not wrap.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- ob_pkg changes:
  - add status_t values S_BadOpcode, S_BadQty and S_BadPrice;
  - add a function is_valid_bcd(price_t) returning 1 when every digit is ≤ 9;
  - add FIFO_DEPTH_DEFAULT=4.
- Existing ob_pkg cmd_t, uid_t, opcode_t, oprand_buy_t and oprand_sell_t are reused unchanged.
- One sub-module, ob_cmd_fifo: parameterised storage plus pointer and full/empty logic. Validation, reject register and issue logic stay in ob_cmd_ingress.

Test Plan:
- Reset, then Buy uid=0x11 qty=10 price=0x0123 with cmd_full_r=0 -> cmd_vld_r pulses exactly one cycle, 2 edges after in_vld; cmd_r matches; rej_vld_r stays 0.
- Sell qty=0 uid=0x22 -> no cmd_vld_r; rej_vld_r=1, rej_uid_r=0x22, rej_status_r=S_BadQty; in_ready=0 until rej_accept, which clears rej_vld_r at the next edge.
- Buy price=0x01A5 uid=0x33 -> S_BadPrice. Opcode outside the legal set with qty=0 -> S_BadOpcode (priority check).
- cmd_full_r=1, push 5 valid commands with FIFO_DEPTH=4 -> in_ready low after 4; release cmd_full_r -> the 5 commands issue in order uids 1..5, none dropped or duplicated.
- Assert rst asynchronously with 3 entries queued and a reject pending -> all outputs return to reset values immediately; no further cmd_vld_r after deassertion.
- With OB_CMD_INGRESS_STATS_EN: 6 valid and 2 invalid transfers -> stat_acc_r=6, stat_rej_r=2.
